// File: rtl/mul_seq_unit.sv
// Sequential radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// The EX stage stalls on mul_busy; mul_done pulses one cycle with a registered result.

`ifndef MUL_SEQ_UNIT_DEFS
`define MUL_SEQ_UNIT_DEFS
`define DATA_BUS      31:0
`define FUNCT_BUS     2:0
`define FUNCT_MUL     3'b000
`define FUNCT_MULH    3'b001
`define FUNCT_MULHSU  3'b010
`define FUNCT_MULHU   3'b011
`endif

module mul_seq_unit #(
  parameter int unsigned ITER = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [`FUNCT_BUS] funct,
  input  logic              mul_en,
  input  logic              mul_flush,
  input  logic [`DATA_BUS]  operand_1,
  input  logic [`DATA_BUS]  operand_2,
  output logic              mul_busy,
  output logic              mul_done,
  output logic [`DATA_BUS]  result
);

  localparam int unsigned CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        prod_q, prod_d;
  logic [31:0]        mcand_q, mcand_d;
  logic [31:0]        mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic               hi_q, hi_d;
  logic [31:0]        result_q, result_d;

  // Accept-time operand decode: signedness, magnitudes and result sign.
  logic               op1_signed, op2_signed, hi_sel;
  logic               op1_neg, op2_neg;
  logic [31:0]        mag_1, mag_2;
  logic               zero_op;

  always_comb begin
    op1_signed = 1'b0;
    op2_signed = 1'b0;
    hi_sel     = 1'b0;
    case (funct)
      `FUNCT_MULH: begin
        op1_signed = 1'b1;
        op2_signed = 1'b1;
        hi_sel     = 1'b1;
      end
      `FUNCT_MULHSU: begin
        op1_signed = 1'b1;
        hi_sel     = 1'b1;
      end
      `FUNCT_MULHU: begin
        hi_sel     = 1'b1;
      end
      default: begin
        hi_sel     = 1'b0;
      end
    endcase
  end

  // 0x80000000 negates to itself, which is exactly its 32-bit unsigned magnitude.
  assign op1_neg = op1_signed & operand_1[31];
  assign op2_neg = op2_signed & operand_2[31];
  assign mag_1   = op1_neg ? (~operand_1 + 32'd1) : operand_1;
  assign mag_2   = op2_neg ? (~operand_2 + 32'd1) : operand_2;
  assign zero_op = (operand_1 == 32'd0) || (operand_2 == 32'd0);

  // One iteration: conditional add into the upper half with a 33rd carry bit, then shift right.
  logic [32:0] step_sum;
  logic [63:0] prod_step;
  logic [63:0] final_prod;
  logic [31:0] final_res;

  assign step_sum   = {1'b0, prod_q[63:32]} + (mplier_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign prod_step  = {step_sum, prod_q[31:1]};
  assign final_prod = neg_q ? (~prod_step + 64'd1) : prod_step;
  assign final_res  = hi_q ? final_prod[63:32] : final_prod[31:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    result_d = result_q;

    if (mul_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mul_en) begin
            mcand_d  = mag_1;
            mplier_d = mag_2;
            neg_d    = op1_neg ^ op2_neg;
            hi_d     = hi_sel;
            cnt_d    = '0;
            prod_d   = 64'd0;
            if (zero_op) begin
              state_d  = S_DONE;
              result_d = 32'd0;
            end else begin
              state_d  = S_CALC;
            end
          end
        end
        S_CALC: begin
          prod_d   = prod_step;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_d  = S_DONE;
            cnt_d    = '0;
            result_d = final_res;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= 64'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      result_q <= result_d;
    end
  end

  assign mul_busy = (state_q == S_CALC);
  assign mul_done = (state_q == S_DONE);
  assign result   = result_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Bench for mul_seq_unit: directed vectors with literal expectations, plus a
// cycle-level behavioural model compared against the outputs on every falling edge.

module tb_mul_seq_unit;

  localparam int LAT = 33;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic [2:0]  funct     = 3'd0;
  logic        mul_en    = 1'b0;
  logic        mul_flush = 1'b0;
  logic [31:0] operand_1 = 32'd0;
  logic [31:0] operand_2 = 32'd0;
  logic        mul_busy;
  logic        mul_done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  mul_seq_unit #(.ITER(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .funct     (funct),
    .mul_en    (mul_en),
    .mul_flush (mul_flush),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .mul_busy  (mul_busy),
    .mul_done  (mul_done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product from plain 64-bit arithmetic on sign/zero-extended operands.
  function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = longint'({32'd0, a});
    sb = longint'({32'd0, b});
    if (f == 3'd1 || f == 3'd2) sa = longint'($signed(a));
    if (f == 3'd1) sb = longint'($signed(b));
    p = sa * sb;
    if (f == 3'd1 || f == 3'd2 || f == 3'd3) return p[63:32];
    return p[31:0];
  endfunction

  // Timing model: a request accepted in idle keeps busy for 32 cycles then done for one.
  int          m_cnt     = 0;
  logic        m_done    = 1'b0;
  logic [31:0] m_result  = 32'd0;
  logic [31:0] m_pending = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt    <= 0;
      m_done   <= 1'b0;
      m_result <= 32'd0;
    end else if (mul_flush) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt  <= m_cnt - 1;
      m_done <= (m_cnt == 1);
      if (m_cnt == 1) m_result <= m_pending;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (mul_en) begin
      if (operand_1 == 32'd0 || operand_2 == 32'd0) begin
        m_done   <= 1'b1;
        m_result <= 32'd0;
      end else begin
        m_pending <= ref_mul(funct, operand_1, operand_2);
        m_cnt     <= LAT - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", {31'd0, mul_busy}, 32'd0);
      check("rst_done", {31'd0, mul_done}, 32'd0);
      check("rst_result", result, 32'd0);
    end else begin
      check("model_busy", {31'd0, mul_busy}, {31'd0, (m_cnt > 0)});
      check("model_done", {31'd0, mul_done}, {31'd0, m_done});
      check("model_result", result, m_result);
    end
  end

  // inj_kind: 0 none, 1 extra mul_en with other operands, 2 flush; injected at cycle inj_cyc.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat,
                        input int inj_cyc, input int inj_kind);
    int cyc;
    @(negedge clk);
    funct = f; operand_1 = a; operand_2 = b; mul_en = 1'b1;
    @(negedge clk);
    mul_en = 1'b0; funct = 3'd3;
    operand_1 = $urandom; operand_2 = $urandom_range(1, 32'h7fff_ffff);
    cyc = 1;
    while (cyc <= 40 && !mul_done) begin
      if (cyc == inj_cyc && inj_kind == 1) begin
        mul_en = 1'b1; funct = 3'd3; operand_1 = 32'd9; operand_2 = 32'd9;
      end
      if (cyc == inj_cyc && inj_kind == 2) mul_flush = 1'b1;
      @(negedge clk);
      mul_en = 1'b0; mul_flush = 1'b0;
      cyc++;
    end
    if (inj_kind == 2) begin
      check("flush_no_done", {31'd0, mul_done}, 32'd0);
      check("flush_result_kept", result, exp_res);
    end else begin
      check("latency", cyc, exp_lat);
      check("result", result, exp_res);
      @(negedge clk);
      check("done_one_cycle", {31'd0, mul_done}, 32'd0);
      check("result_held", result, exp_res);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("init_busy", {31'd0, mul_busy}, 32'd0);
    check("init_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, mul_busy}, 32'd0);

    run_op(3'd0, 32'd7,        32'd6,        32'h0000_002A, LAT, 0, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT, 0, 0);
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LAT, 0, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT, 0, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, LAT, 0, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT, 0, 0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT, 0, 0);
    run_op(3'd1, 32'hFFFF_FFF9, 32'd6,        32'hFFFF_FFFF, LAT, 0, 0);
    run_op(3'd0, 32'hFFFF_FFF9, 32'd6,        32'hFFFF_FFD6, LAT, 0, 0);
    run_op(3'd7, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, LAT, 0, 0);
    run_op(3'd0, 32'h1234_5678, 32'd0,        32'h0000_0000, 1,   0, 0);
    run_op(3'd1, 32'd0,        32'h8000_0000, 32'h0000_0000, 1,   0, 0);

    run_op(3'd0, 32'd7, 32'd6, 32'h0000_002A, LAT, 0,  0);
    run_op(3'd0, 32'd3, 32'd5, 32'h0000_002A, LAT, 10, 2);
    run_op(3'd0, 32'd3, 32'd5, 32'h0000_000F, LAT, 0,  0);
    run_op(3'd0, 32'd4, 32'd5, 32'h0000_0014, LAT, 5,  1);

    // Back-to-back requests with mul_en held high through CALC and DONE.
    @(negedge clk);
    funct = 3'd3; operand_1 = 32'hDEAD_BEEF; operand_2 = 32'h0000_1000; mul_en = 1'b1;
    repeat (80) @(negedge clk);
    mul_en = 1'b0;
    check("held_en_result", result, 32'h0000_0DEA);

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    funct = 3'd3; operand_1 = 32'hFFFF_FFFF; operand_2 = 32'd3; mul_en = 1'b1;
    @(negedge clk);
    mul_en = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_reset_busy", {31'd0, mul_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, mul_busy}, 32'd0);
    check("async_rst_done", {31'd0, mul_done}, 32'd0);
    check("async_rst_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_no_done", {31'd0, mul_done}, 32'd0);
    check("post_reset_result", result, 32'd0);

    run_op(3'd3, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002, LAT, 0, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
